// File: rtl/tty_pkg.sv
// rtl/tty_pkg.sv - control codes and FSM state encoding for the tty text writer
package tty_pkg;

   localparam logic [7:0] ASCII_BS        = 8'h08;
   localparam logic [7:0] ASCII_LF        = 8'h0A;
   localparam logic [7:0] ASCII_FF        = 8'h0C;
   localparam logic [7:0] ASCII_CR        = 8'h0D;
   localparam logic [7:0] ASCII_PRINT_MIN = 8'h20;
   localparam logic [7:0] ASCII_PRINT_MAX = 8'h7E;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_CLR_ROW = 2'd1,
      ST_CLR_ALL = 2'd2
   } tty_state_t;

endpackage

// File: rtl/tty_clear_seq.sv
// rtl/tty_clear_seq.sv - blank-fill sweep counter (one row or whole screen)
module tty_clear_seq #(
   parameter int unsigned HORZ_CNT     = 16,
   parameter int unsigned VERT_CNT     = 2,
   parameter int unsigned HORZ_W       = 4,
   parameter int unsigned VERT_W       = 1,
   parameter bit          START_ACTIVE = 1'b0
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start_i,
   input  logic              all_i,
   input  logic [VERT_W-1:0] row_i,
   output logic [HORZ_W-1:0] col_o,
   output logic [VERT_W-1:0] row_o,
   output logic              wr_o,
   output logic              done_o
);

   localparam logic [HORZ_W-1:0] COL_LAST = HORZ_W'(HORZ_CNT - 1);
   localparam logic [VERT_W-1:0] ROW_LAST = VERT_W'(VERT_CNT - 1);
   localparam logic [HORZ_W-1:0] COL_ONE  = HORZ_W'(1);
   localparam logic [VERT_W-1:0] ROW_ONE  = VERT_W'(1);

   logic              active_q, active_d;
   logic              all_q, all_d;
   logic [HORZ_W-1:0] col_q, col_d;
   logic [VERT_W-1:0] row_q, row_d;
   logic              last;

   // Last cell: end of the row, and for a full sweep also the last row.
   assign last   = (col_q == COL_LAST) && (!all_q || (row_q == ROW_LAST));
   assign col_o  = col_q;
   assign row_o  = all_q ? row_q : row_i;
   assign wr_o   = active_q;
   assign done_o = active_q & last;

   // Next-state: restart on start_i, otherwise advance row-major until the last cell.
   always_comb begin
      active_d = active_q;
      all_d    = all_q;
      col_d    = col_q;
      row_d    = row_q;
      if (start_i) begin
         active_d = 1'b1;
         all_d    = all_i;
         col_d    = '0;
         row_d    = '0;
      end else if (active_q) begin
         if (last) begin
            active_d = 1'b0;
         end else if (col_q == COL_LAST) begin
            col_d = '0;
            row_d = row_q + ROW_ONE;
         end else begin
            col_d = col_q + COL_ONE;
         end
      end
   end

   // Sweep registers; a power-up sweep starts armed as a full-screen clear.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         active_q <= START_ACTIVE;
         all_q    <= START_ACTIVE;
         col_q    <= '0;
         row_q    <= '0;
      end else begin
         active_q <= active_d;
         all_q    <= all_d;
         col_q    <= col_d;
         row_q    <= row_d;
      end
   end

endmodule

// File: rtl/tty_text_writer.sv
// rtl/tty_text_writer.sv - byte stream to character-cell writes with cursor, wrap and clear (TTY_CLEAR_ON_RESET_EN: blank screen after reset)
module tty_text_writer
   import tty_pkg::*;
#(
   parameter int unsigned CHAR_HORZ_CNT = 16,
   parameter int unsigned CHAR_VERT_CNT = 2,
   parameter int unsigned CHAR_HORZ_W   = $clog2(CHAR_HORZ_CNT),
   parameter int unsigned CHAR_VERT_W   = $clog2(CHAR_VERT_CNT),
   parameter logic [7:0]  BLANK_CHAR    = 8'h20
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [7:0]             in_data,
   output logic [CHAR_HORZ_W-1:0] char_hpos,
   output logic [CHAR_VERT_W-1:0] char_vpos,
   output logic                   char_write_en,
   output logic [7:0]             char_symbol,
   output logic                   cursor_valid,
   output logic                   cursor_display_en,
   output logic [CHAR_HORZ_W-1:0] cursor_hpos,
   output logic [CHAR_VERT_W-1:0] cursor_vpos,
   output logic                   busy
);

   localparam logic [CHAR_HORZ_W-1:0] H_LAST = CHAR_HORZ_W'(CHAR_HORZ_CNT - 1);
   localparam logic [CHAR_VERT_W-1:0] V_LAST = CHAR_VERT_W'(CHAR_VERT_CNT - 1);
   localparam logic [CHAR_HORZ_W-1:0] H_ONE  = CHAR_HORZ_W'(1);
   localparam logic [CHAR_VERT_W-1:0] V_ONE  = CHAR_VERT_W'(1);

`ifdef TTY_CLEAR_ON_RESET_EN
   localparam tty_state_t RESET_STATE    = ST_CLR_ALL;
   localparam bit         SWEEP_ON_RESET = 1'b1;
`else
   localparam tty_state_t RESET_STATE    = ST_IDLE;
   localparam bit         SWEEP_ON_RESET = 1'b0;
`endif

   tty_state_t             state_q, state_d;
   logic [CHAR_HORZ_W-1:0] hpos_q, hpos_d, wr_h_q, wr_h_d;
   logic [CHAR_VERT_W-1:0] vpos_q, vpos_d, wr_v_q, wr_v_d;
   logic [7:0]             sym_q, sym_d;
   logic                   wr_en_q, wr_en_d;
   logic                   in_ready_q, busy_q, disp_q, cur_valid_q;
   logic                   accept, newline, seq_start, seq_all;
   logic [CHAR_HORZ_W-1:0] seq_col;
   logic [CHAR_VERT_W-1:0] seq_row;
   logic                   seq_wr, seq_done;

   // The sweep row in row mode is the cursor row, which has already moved by the time the sweep runs.
   tty_clear_seq #(
      .HORZ_CNT     (CHAR_HORZ_CNT),
      .VERT_CNT     (CHAR_VERT_CNT),
      .HORZ_W       (CHAR_HORZ_W),
      .VERT_W       (CHAR_VERT_W),
      .START_ACTIVE (SWEEP_ON_RESET)
   ) u_clear_seq (
      .clk     (clk),
      .rst_n   (rst_n),
      .start_i (seq_start),
      .all_i   (seq_all),
      .row_i   (vpos_q),
      .col_o   (seq_col),
      .row_o   (seq_row),
      .wr_o    (seq_wr),
      .done_o  (seq_done)
   );

   assign accept = in_valid & in_ready_q;

   // Byte interpretation in IDLE; during a clear, forward sweep cells as blank writes.
   always_comb begin
      state_d   = state_q;
      hpos_d    = hpos_q;
      vpos_d    = vpos_q;
      wr_en_d   = 1'b0;
      wr_h_d    = wr_h_q;
      wr_v_d    = wr_v_q;
      sym_d     = sym_q;
      newline   = 1'b0;
      seq_start = 1'b0;
      seq_all   = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (accept) begin
               if ((in_data >= ASCII_PRINT_MIN) && (in_data <= ASCII_PRINT_MAX)) begin
                  wr_en_d = 1'b1;
                  wr_h_d  = hpos_q;
                  wr_v_d  = vpos_q;
                  sym_d   = in_data;
                  if (hpos_q == H_LAST) begin
                     hpos_d  = '0;
                     newline = 1'b1;
                  end else begin
                     hpos_d = hpos_q + H_ONE;
                  end
               end else if (in_data == ASCII_LF) begin
                  hpos_d  = '0;
                  newline = 1'b1;
               end else if (in_data == ASCII_CR) begin
                  hpos_d = '0;
               end else if (in_data == ASCII_BS) begin
                  if (hpos_q != '0) begin
                     hpos_d  = hpos_q - H_ONE;
                     wr_en_d = 1'b1;
                     wr_h_d  = hpos_q - H_ONE;
                     wr_v_d  = vpos_q;
                     sym_d   = BLANK_CHAR;
                  end
               end else if (in_data == ASCII_FF) begin
                  hpos_d    = '0;
                  vpos_d    = '0;
                  state_d   = ST_CLR_ALL;
                  seq_start = 1'b1;
                  seq_all   = 1'b1;
               end
               if (newline) begin
                  vpos_d    = (vpos_q == V_LAST) ? '0 : vpos_q + V_ONE;
                  state_d   = ST_CLR_ROW;
                  seq_start = 1'b1;
               end
            end
         end
         default: begin
            if (seq_wr) begin
               wr_en_d = 1'b1;
               wr_h_d  = seq_col;
               wr_v_d  = seq_row;
               sym_d   = BLANK_CHAR;
            end
            if (seq_done) begin
               state_d = ST_IDLE;
            end
         end
      endcase
   end

   // Registered outputs; handshake/status flags are decoded from the next state so they track state_q.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= RESET_STATE;
         hpos_q      <= '0;
         vpos_q      <= '0;
         wr_en_q     <= 1'b0;
         wr_h_q      <= '0;
         wr_v_q      <= '0;
         sym_q       <= BLANK_CHAR;
         in_ready_q  <= 1'b0;
         busy_q      <= 1'b0;
         disp_q      <= 1'b0;
         cur_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         hpos_q      <= hpos_d;
         vpos_q      <= vpos_d;
         wr_en_q     <= wr_en_d;
         wr_h_q      <= wr_h_d;
         wr_v_q      <= wr_v_d;
         sym_q       <= sym_d;
         in_ready_q  <= (state_d == ST_IDLE);
         busy_q      <= (state_d != ST_IDLE);
         disp_q      <= (state_d == ST_IDLE);
         cur_valid_q <= (hpos_d != hpos_q) || (vpos_d != vpos_q);
      end
   end

   assign in_ready          = in_ready_q;
   assign busy              = busy_q;
   assign cursor_display_en = disp_q;
   assign cursor_valid      = cur_valid_q;
   assign cursor_hpos       = hpos_q;
   assign cursor_vpos       = vpos_q;
   assign char_write_en     = wr_en_q;
   assign char_hpos         = wr_h_q;
   assign char_vpos         = wr_v_q;
   assign char_symbol       = sym_q;

endmodule
